// File: rtl/mux_n_to_1_pipelined.sv
// N-channel, W-bit multiplexer with one registered output stage and valid/ready
// handshaking; channel chosen by sel (RR=0) or by round-robin among valid inputs (RR=1).
module mux_n_to_1_pipelined #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 8,
  parameter int unsigned RR = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*W-1:0]       in_data,
  output logic [N-1:0]         in_ready,
  input  logic [$clog2(N)-1:0] sel,
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int unsigned SW = $clog2(N);
  typedef logic [SW-1:0] idx_t;

  logic         out_valid_q;
  logic [W-1:0] out_data_q;
  idx_t         grant_q;
  idx_t         ptr_q;

  logic         space;
  logic         chosen_vld;
  idx_t         chosen_idx;
  idx_t         scan_idx;
  logic         xfer;
  logic [W-1:0] xfer_data;

  assign space = !out_valid_q || out_ready;

  // Round-robin scans downwards so the channel closest after ptr_q wins last.
  always_comb begin
    chosen_vld = 1'b0;
    chosen_idx = '0;
    scan_idx   = '0;
    if (RR != 0) begin
      for (int k = int'(N); k >= 1; k--) begin
        scan_idx = idx_t'((int'(ptr_q) + k) % int'(N));
        if (in_valid[scan_idx]) begin
          chosen_vld = 1'b1;
          chosen_idx = scan_idx;
        end
      end
    end else begin
      chosen_vld = (int'(sel) < int'(N));
      chosen_idx = sel;
    end
  end

  always_comb begin
    in_ready  = '0;
    xfer_data = '0;
    for (int c = 0; c < int'(N); c++) begin
      in_ready[c] = space && chosen_vld && (chosen_idx == idx_t'(c));
      if (in_ready[c]) begin
        xfer_data = in_data[c*W +: W];
      end
    end
  end

  assign xfer = |(in_valid & in_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      grant_q     <= '0;
      ptr_q       <= idx_t'(N - 1);
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= xfer_data;
      grant_q     <= chosen_idx;
      if (RR != 0) begin
        ptr_q <= chosen_idx;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign grant_idx = grant_q;

endmodule

// File: tb/tb_mux_n_to_1_pipelined.sv
// Bench for mux_n_to_1_pipelined: directed tables for sel and round-robin modes,
// reset/corner sequences, and a randomized run against a behavioural model.
module tb_mux_n_to_1_pipelined;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // dut0: RR=0, N=4; dut1: RR=1, N=4; dut3: RR=0, N=3 (sel can exceed N-1)
  logic [3:0]  v0, ir0, v1, ir1;
  logic [31:0] d0, d1;
  logic [1:0]  s0, g0, s1, g1;
  logic        or0, ov0, or1, ov1;
  logic [7:0]  od0, od1;
  logic [2:0]  v3, ir3;
  logic [23:0] d3;
  logic [1:0]  s3, g3;
  logic        or3, ov3;
  logic [7:0]  od3;

  mux_n_to_1_pipelined #(.N(4), .W(8), .RR(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_data(d0), .in_ready(ir0), .sel(s0),
    .out_valid(ov0), .out_data(od0), .out_ready(or0), .grant_idx(g0));
  mux_n_to_1_pipelined #(.N(4), .W(8), .RR(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(d1), .in_ready(ir1), .sel(s1),
    .out_valid(ov1), .out_data(od1), .out_ready(or1), .grant_idx(g1));
  mux_n_to_1_pipelined #(.N(3), .W(8), .RR(0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_data(d3), .in_ready(ir3), .sel(s3),
    .out_valid(ov3), .out_data(od3), .out_ready(or3), .grant_idx(g3));

  typedef struct packed {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [1:0]  sel;
    logic        oready;
    logic [3:0]  exp_ready;
    logic        exp_ov;
    logic [7:0]  exp_od;
    logic [1:0]  exp_g;
  } vec_t;

  vec_t tbl0[9];
  vec_t tbl1[12];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int which, input int idx, input vec_t t);
    @(negedge clk);
    if (which == 0) begin
      v0 = t.valid; d0 = t.data; s0 = t.sel; or0 = t.oready;
    end else begin
      v1 = t.valid; d1 = t.data; s1 = t.sel; or1 = t.oready;
    end
    #1;
    chk($sformatf("dut%0d[%0d] in_ready", which, idx), (which == 0) ? 32'(ir0) : 32'(ir1),
        32'(t.exp_ready));
    @(posedge clk);
    #1;
    chk($sformatf("dut%0d[%0d] out_valid", which, idx), (which == 0) ? 32'(ov0) : 32'(ov1),
        32'(t.exp_ov));
    chk($sformatf("dut%0d[%0d] out_data", which, idx), (which == 0) ? 32'(od0) : 32'(od1),
        32'(t.exp_od));
    chk($sformatf("dut%0d[%0d] grant_idx", which, idx), (which == 0) ? 32'(g0) : 32'(g1),
        32'(t.exp_g));
  endtask

  function automatic logic [3:0] model_rdy(input bit rr, input logic [3:0] v, input logic [1:0] s,
                                           input bit ov, input bit ordy, input logic [1:0] ptr);
    if (ov && !ordy) return 4'b0000;
    if (!rr) return 4'b0001 << s;
    for (int k = 1; k <= 4; k++) begin
      if (v[(int'(ptr) + k) % 4]) return 4'b0001 << ((int'(ptr) + k) % 4);
    end
    return 4'b0000;
  endfunction

  initial begin
    // RR=0 table; channel data ch3..ch0 = 44,A5,22,11
    tbl0[0] = '{4'b1111, 32'h44A52211, 2'd2, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    tbl0[1] = '{4'b1111, 32'h44A52211, 2'd1, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2};
    tbl0[2] = '{4'b1111, 32'h44A52211, 2'd1, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2};
    tbl0[3] = '{4'b1111, 32'h44A52211, 2'd1, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2};
    tbl0[4] = '{4'b1111, 32'h44A52211, 2'd1, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
    tbl0[5] = '{4'b0000, 32'h44A52211, 2'd3, 1'b1, 4'b1000, 1'b0, 8'h22, 2'd1};
    tbl0[6] = '{4'b0001, 32'h44A52211, 2'd0, 1'b0, 4'b0001, 1'b1, 8'h11, 2'd0};
    tbl0[7] = '{4'b1000, 32'h44A52211, 2'd3, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    tbl0[8] = '{4'b0000, 32'h44A52211, 2'd0, 1'b1, 4'b0001, 1'b0, 8'h44, 2'd3};
    // RR=1 table; channel data ch3..ch0 = 44,33,22,11
    tbl1[0]  = '{4'b1111, 32'h44332211, 2'd0, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    tbl1[1]  = '{4'b1111, 32'h44332211, 2'd0, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
    tbl1[2]  = '{4'b1111, 32'h44332211, 2'd0, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
    tbl1[3]  = '{4'b1111, 32'h44332211, 2'd0, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    tbl1[4]  = '{4'b1111, 32'h44332211, 2'd0, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    tbl1[5]  = '{4'b1111, 32'h44332211, 2'd0, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
    tbl1[6]  = '{4'b1010, 32'h44332211, 2'd0, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    tbl1[7]  = '{4'b1010, 32'h44332211, 2'd0, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
    tbl1[8]  = '{4'b1010, 32'h44332211, 2'd0, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    tbl1[9]  = '{4'b0000, 32'h44332211, 2'd0, 1'b1, 4'b0000, 1'b0, 8'h44, 2'd3};
    tbl1[10] = '{4'b1000, 32'h44332211, 2'd0, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    tbl1[11] = '{4'b0001, 32'h44332211, 2'd0, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};

    // Reset held for 2 cycles with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      v0 = 4'($urandom); d0 = $urandom; s0 = 2'($urandom); or0 = 1'($urandom);
      v1 = 4'($urandom); d1 = $urandom; s1 = 2'($urandom); or1 = 1'($urandom);
      v3 = 3'($urandom); d3 = 24'($urandom); s3 = 2'($urandom); or3 = 1'($urandom);
    end
    @(negedge clk);
    v1 = 4'b0000; s3 = 2'd3;
    #1;
    chk("reset ov0", 32'(ov0), 32'd0);
    chk("reset od0", 32'(od0), 32'd0);
    chk("reset g0", 32'(g0), 32'd0);
    chk("reset ov1", 32'(ov1), 32'd0);
    chk("reset od1", 32'(od1), 32'd0);
    chk("reset g1", 32'(g1), 32'd0);
    chk("reset ir1", 32'(ir1), 32'd0);
    chk("reset ir3", 32'(ir3), 32'd0);
    chk("reset ov3", 32'(ov3), 32'd0);
    v0 = 4'b0000; or0 = 1'b1; or1 = 1'b1; v3 = 3'b000; or3 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(0, i, tbl0[i]);
    for (int i = 0; i < 12; i++) run_vec(1, i, tbl1[i]);

    // Hold the ch0 word under backpressure, then reset: word must be dropped
    @(negedge clk);
    v1 = 4'b0000; or1 = 1'b0;
    @(posedge clk);
    #1;
    chk("rr hold ov", 32'(ov1), 32'd1);
    chk("rr hold od", 32'(od1), 32'h11);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid reset ov", 32'(ov1), 32'd0);
    chk("mid reset od", 32'(od1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    v1 = 4'b1111; or1 = 1'b1;
    #1;
    chk("ptr after reset ir", 32'(ir1), 32'b0001);

    // sel beyond the channel count selects nothing
    @(negedge clk);
    v1 = 4'b0000;
    v3 = 3'b111; d3 = 24'hC0B0A0; s3 = 2'd3; or3 = 1'b1;
    #1;
    chk("sel>=N ir3", 32'(ir3), 32'd0);
    @(posedge clk);
    #1;
    chk("sel>=N ov3", 32'(ov3), 32'd0);
    @(negedge clk);
    s3 = 2'd2;
    #1;
    chk("n3 sel2 ir3", 32'(ir3), 32'b100);
    @(posedge clk);
    #1;
    chk("n3 sel2 od3", 32'(od3), 32'hC0);
    chk("n3 sel2 g3", 32'(g3), 32'd2);

    // Randomised run of dut0 and dut1 against a behavioural model
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    begin
      logic       m_ov[2];
      logic [7:0] m_od[2];
      logic [1:0] m_g[2];
      logic [1:0] m_ptr[2];
      logic [3:0] er, v, rdy, hit;
      logic [31:0] d;
      logic [1:0] s;
      logic       ordy;
      for (int u = 0; u < 2; u++) begin
        m_ov[u] = 1'b0; m_od[u] = 8'h00; m_g[u] = 2'd0; m_ptr[u] = 2'd3;
      end
      for (int i = 0; i < 10000; i++) begin
        @(negedge clk);
        v0 = 4'($urandom); d0 = $urandom; s0 = 2'($urandom); or0 = 1'($urandom);
        v1 = 4'($urandom); d1 = $urandom; s1 = 2'($urandom); or1 = 1'($urandom);
        #1;
        for (int u = 0; u < 2; u++) begin
          v = (u == 0) ? v0 : v1; d = (u == 0) ? d0 : d1; s = (u == 0) ? s0 : s1;
          ordy = (u == 0) ? or0 : or1; rdy = (u == 0) ? ir0 : ir1;
          er = model_rdy(u == 1, v, s, m_ov[u], ordy, m_ptr[u]);
          chk($sformatf("rand%0d dut%0d in_ready", i, u), 32'(rdy), 32'(er));
          hit = er & v;
          if (hit != 4'b0000) begin
            for (int c = 0; c < 4; c++) begin
              if (hit[c]) begin
                m_ov[u] = 1'b1; m_od[u] = d[c*8 +: 8]; m_g[u] = 2'(c); m_ptr[u] = 2'(c);
              end
            end
          end else if (ordy) begin
            m_ov[u] = 1'b0;
          end
        end
        @(posedge clk);
        #1;
        chk($sformatf("rand%0d dut0 out", i), {ov0, od0, g0}, {m_ov[0], m_od[0], m_g[0]});
        chk($sformatf("rand%0d dut1 out", i), {ov1, od1, g1}, {m_ov[1], m_od[1], m_g[1]});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
